cache_arbiter: RTL and testbench
================================

# cache_arbiter

Arbitrates between the instruction-cache and data-cache miss ports and one shared line-wide physical-memory port (cacheline adaptor side). Accepts one 256-bit line read (I-side) or line read/write (D-side) at a time, latches the winning request, holds it on the shared port until the memory responds, then routes the response back to the winner. Sits below both caches and above the cacheline adaptor in the mp4 memory hierarchy.

## Interface
- LINE_W, 256, cache line width in bits
- ADDR_W, 32, address width
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- i_read  input  1  I-cache line read request, held until i_resp
- i_address  input  ADDR_W  I-cache line address
- i_rdata  output  LINE_W  read line to I-cache
- i_resp  output  1  one-cycle completion pulse to I-cache
- d_read  input  1  D-cache line read request, held until d_resp
- d_write  input  1  D-cache line writeback request, held until d_resp
- d_address  input  ADDR_W  D-cache line address
- d_wdata  input  LINE_W  D-cache writeback line
- d_rdata  output  LINE_W  read line to D-cache
- d_resp  output  1  one-cycle completion pulse to D-cache
- mem_read  output  1  shared-port read strobe
- mem_write  output  1  shared-port write strobe
- mem_address  output  ADDR_W  shared-port address
- mem_wdata  output  LINE_W  shared-port write line
- mem_rdata  input  LINE_W  shared-port read line
- mem_resp  input  1  shared-port completion pulse

## Operation
- FSM states: ARB_IDLE, ARB_I, ARB_D.
- ARB_IDLE: no mem strobe asserted. If i_read or (d_read|d_write), grant one and capture address, wdata, op into registers; next state ARB_I/ARB_D.
- Fixed priority (default): D-side wins when both request.
- ARB_I: mem_read=1, mem_address=latched I address. On mem_resp: i_resp=1 same cycle, next ARB_IDLE.
- ARB_D: mem_read or mem_write per latched op, address/wdata from latches. On mem_resp: d_resp=1 same cycle, next ARB_IDLE.
- i_rdata and d_rdata are driven continuously from mem_rdata; valid only when the matching resp is high.
- d_read and d_write both high: illegal; write wins.
- Requester dropping its request mid-transaction: the latched transaction still completes (adaptor cannot abort); resp pulse still issued, ignored by the cache.
- mem_resp in ARB_IDLE: ignored, no resp pulse.

## Timing
- Reset (rst low, asynchronous): state ARB_IDLE; mem_read, mem_write, i_resp, d_resp = 0; mem_address, mem_wdata latches = 0; priority pointer = I-next.
- Grant latency: request sampled in ARB_IDLE at edge N; mem strobe asserted from cycle N+1.
- Completion: resp combinational with mem_resp, exactly one cycle.
- Turnaround: minimum one ARB_IDLE cycle between consecutive transactions; a still-pending loser is granted on the edge leaving that idle cycle.
- Reset mid-transaction: strobes drop immediately; no resp issued; pending transaction lost.

## Configuration
- ARB_ROUND_ROBIN_EN defined: one-bit last-grant register; on simultaneous requests, grant the side not served last; single requests granted regardless. Register updates on each grant.
- Undefined: fixed D-over-I priority; no last-grant register.

## Structure
- Package arb_pkg: enum arb_state_t {ARB_IDLE, ARB_I, ARB_D}; localparams LINE_W, ADDR_W defaults; enum arb_op_t {ARB_OP_READ, ARB_OP_WRITE}.
- Single module; grant selection is a small combinational block inside it, no sub-module.

## Test plan
- I-only: i_read=1, i_address=0x0000_0060, mem_resp after 5 cycles with mem_rdata=0xA5..A5 -> mem_read=1 addr 0x60 from next cycle; i_resp one cycle with i_rdata=0xA5..A5; d_resp stays 0.
- D writeback: d_write=1, d_address=0x0000_1000, d_wdata=0x1234..  -> mem_write=1, mem_wdata=0x1234.., d_resp on mem_resp, mem_read never high.
- Simultaneous, fixed priority: i_read and d_read at same edge -> ARB_D first; after d_resp, one idle cycle, then ARB_I; i_resp after second mem_resp.
- Simultaneous ×2 with ARB_ROUND_ROBIN_EN: first tie grants I, second tie grants D.
- Abandoned request: d_read dropped during ARB_D -> mem_read held until mem_resp; returns to ARB_IDLE.
- Reset mid-op: rst low in ARB_I -> mem_read=0 same cycle, no i_resp; after release, pending i_read regranted from ARB_IDLE.

Source files
------------

// File: rtl/cache_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg
// Shared types and default widths for the cache arbiter.
//   arb_state_t : arbiter FSM states (idle, serving I-side, serving D-side)
//   arb_op_t    : latched memory operation for a D-side grant
//   LINE_W      : cache line width in bits
//   ADDR_W      : physical address width
// ----------------------------------------------------------------------------
package arb_pkg;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_I,
    ARB_D
  } arb_state_t;

  typedef enum logic {
    ARB_OP_READ,
    ARB_OP_WRITE
  } arb_op_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// ----------------------------------------------------------------------------
// cache_arbiter_if
// Bundles the I-cache miss port, the D-cache miss port and the shared
// line-wide memory port seen by the arbiter.
//   modport master : the arbiter (it masters the shared memory port and
//                    answers both cache ports)
//   modport slave  : the surroundings (caches + cacheline adaptor)
// Signals:
//   i_read/i_address -> i_rdata/i_resp            I-cache line read
//   d_read/d_write/d_address/d_wdata -> d_rdata/d_resp   D-cache line read/writeback
//   mem_read/mem_write/mem_address/mem_wdata -> mem_rdata/mem_resp  shared port
// ----------------------------------------------------------------------------
interface cache_arbiter_if #(
  parameter int LINE_W = arb_pkg::LINE_W,
  parameter int ADDR_W = arb_pkg::ADDR_W
) ();

  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport master (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
           mem_read, mem_write, mem_address, mem_wdata
  );

  modport slave (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
           mem_read, mem_write, mem_address, mem_wdata
  );

endinterface

// File: rtl/cache_arbiter.sv
// ----------------------------------------------------------------------------
// cache_arbiter
// Serialises I-cache line reads and D-cache line reads/writebacks onto one
// shared line-wide memory port. One transaction at a time: the winner's
// address/data/op are latched in ARB_IDLE, held on the memory port until
// mem_resp, and the response is routed back to the winner in the same cycle.
//
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-low reset
//   bus  : cache_arbiter_if.master (both cache ports + shared memory port)
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   undefined : fixed priority, D-side wins a tie
//   defined   : a tie goes to the side not served by the previous grant
// ----------------------------------------------------------------------------
module cache_arbiter
  import arb_pkg::*;
(
  input logic              clk,
  input logic              rst,
  cache_arbiter_if.master  bus
);

  arb_state_t        state_q, state_d;
  arb_op_t           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic d_req;
  logic grant_d;   // in ARB_IDLE: the D-side wins this cycle

  assign d_req = bus.d_read | bus.d_write;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = D-side received the most recent grant. Reset to D so that the first
  // tie after reset goes to the I-side.
  logic last_d_q, last_d_d;

  assign grant_d = d_req & (~bus.i_read | ~last_d_q);

  always_comb begin
    last_d_d = last_d_q;
    if (state_q == ARB_IDLE && (d_req || bus.i_read)) begin
      last_d_d = grant_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d_q <= 1'b1;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`else
  assign grant_d = d_req;
`endif

  // State and transaction latches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      op_q    <= ARB_OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state and capture of the winning request
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_d) begin
          state_d = ARB_D;
          addr_d  = bus.d_address;
          wdata_d = bus.d_wdata;
          // read+write together is illegal; the writeback takes precedence
          op_d    = bus.d_write ? ARB_OP_WRITE : ARB_OP_READ;
        end else if (bus.i_read) begin
          state_d = ARB_I;
          addr_d  = bus.i_address;
          op_d    = ARB_OP_READ;
        end
      end
      // The adaptor cannot abort, so a dropped request still runs to mem_resp.
      ARB_I, ARB_D: begin
        if (bus.mem_resp) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Outputs: strobes from state, completions combinational with mem_resp
  always_comb begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.i_resp    = 1'b0;
    bus.d_resp    = 1'b0;
    unique case (state_q)
      ARB_I: begin
        bus.mem_read = 1'b1;
        bus.i_resp   = bus.mem_resp;
      end
      ARB_D: begin
        bus.mem_read  = (op_q == ARB_OP_READ);
        bus.mem_write = (op_q == ARB_OP_WRITE);
        bus.d_resp    = bus.mem_resp;
      end
      default: ;
    endcase
  end

  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.i_rdata     = bus.mem_rdata;
  assign bus.d_rdata     = bus.mem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  cache_arbiter_if bus ();

  cache_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Transaction-level reference model: either no transaction in flight, or
  // one transaction (side, address, data, write) owning the memory port.
  // ---------------------------------------------------------------------
  logic         m_active = 1'b0;
  logic         m_side_d = 1'b0;   // 1: D-side owns the transaction
  logic         m_write  = 1'b0;
  logic [31:0]  m_addr   = '0;
  logic [255:0] m_wdata  = '0;
  logic         m_last_d = 1'b1;   // side granted most recently (D before first grant)

  function automatic logic model_pick_d(input logic ir, input logic dr_any, input logic last_d);
    if (!ir) return 1'b1;          // only D asking (caller ensures someone asks)
    if (!dr_any) return 1'b0;      // only I asking
`ifdef ARB_ROUND_ROBIN_EN
    return !last_d;                // tie: the side not served last
`else
    return 1'b1;                   // tie: D has fixed priority
`endif
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 1'b0;
      m_side_d <= 1'b0;
      m_write  <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_last_d <= 1'b1;
    end else if (m_active) begin
      if (bus.mem_resp) m_active <= 1'b0;
    end else if (bus.i_read || bus.d_read || bus.d_write) begin
      if (model_pick_d(bus.i_read, bus.d_read | bus.d_write, m_last_d)) begin
        m_side_d <= 1'b1;
        m_last_d <= 1'b1;
        m_addr   <= bus.d_address;
        m_wdata  <= bus.d_wdata;
        m_write  <= bus.d_write;
      end else begin
        m_side_d <= 1'b0;
        m_last_d <= 1'b0;
        m_addr   <= bus.i_address;
        m_write  <= 1'b0;
      end
      m_active <= 1'b1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("mem_read",  bus.mem_read,  m_active && !m_write);
    chk("mem_write", bus.mem_write, m_active && m_write);
    chk("i_resp",    bus.i_resp,    m_active && !m_side_d && bus.mem_resp);
    chk("d_resp",    bus.d_resp,    m_active && m_side_d && bus.mem_resp);
    if (m_active) chk("mem_address", bus.mem_address, m_addr);
    if (m_active && m_write) chk("mem_wdata", bus.mem_wdata, m_wdata);
    if (bus.i_resp) chk("i_rdata", bus.i_rdata, bus.mem_rdata);
    if (bus.d_resp) chk("d_rdata", bus.d_rdata, bus.mem_rdata);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  logic [255:0] line_a5;
  logic [255:0] line_12;
  logic [255:0] line_rd;
  logic         tie_first_d;
  logic         ir_seen, dr_seen;

  initial begin
    bus.i_read = 0; bus.i_address = '0;
    bus.d_read = 0; bus.d_write = 0; bus.d_address = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_resp = 0;
    line_a5 = {32{8'hA5}};
    line_12 = {8{32'h1234_5678}};

    // Reset state
    repeat (2) step();
    chk("rst_mem_read",  bus.mem_read,  1'b0);
    chk("rst_mem_write", bus.mem_write, 1'b0);
    chk("rst_mem_addr",  bus.mem_address, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 256'h0);
    rst = 1'b1;
    step();

    // I-only read
    bus.i_read = 1; bus.i_address = 32'h0000_0060;
    step(); settle();
    chk("ionly_read", bus.mem_read, 1'b1);
    chk("ionly_addr", bus.mem_address, 32'h60);
    repeat (4) step();
    bus.mem_resp = 1; bus.mem_rdata = line_a5; settle();
    chk("ionly_resp",  bus.i_resp, 1'b1);
    chk("ionly_rdata", bus.i_rdata, line_a5);
    chk("ionly_dresp", bus.d_resp, 1'b0);
    step();
    bus.i_read = 0; bus.mem_resp = 0; settle();
    chk("ionly_idle", bus.mem_read, 1'b0);

    // D writeback
    step();
    bus.d_write = 1; bus.d_address = 32'h0000_1000; bus.d_wdata = line_12;
    step(); settle();
    chk("wb_write", bus.mem_write, 1'b1);
    chk("wb_wdata", bus.mem_wdata, line_12);
    chk("wb_addr",  bus.mem_address, 32'h1000);
    for (int k = 0; k < 3; k++) begin
      step(); settle();
      chk("wb_no_read", bus.mem_read, 1'b0);
    end
    bus.mem_resp = 1; settle();
    chk("wb_resp", bus.d_resp, 1'b1);
    step();
    bus.d_write = 0; bus.mem_resp = 0;

    // Simultaneous requests (last grant was D)
`ifdef ARB_ROUND_ROBIN_EN
    tie_first_d = 1'b0;
`else
    tie_first_d = 1'b1;
`endif
    step();
    bus.i_read = 1; bus.i_address = 32'h0000_0200;
    bus.d_read = 1; bus.d_address = 32'h0000_0400;
    step(); settle();
    chk("tie1_addr", bus.mem_address, tie_first_d ? 32'h400 : 32'h200);
    step();
    bus.mem_resp = 1; settle();
    chk("tie1_iresp", bus.i_resp, !tie_first_d);
    chk("tie1_dresp", bus.d_resp, tie_first_d);
    step();
    bus.mem_resp = 0;
    if (tie_first_d) bus.d_read = 0; else bus.i_read = 0;
    settle();
    chk("tie_idle", bus.mem_read, 1'b0);
    step(); settle();
    chk("tie2_addr", bus.mem_address, tie_first_d ? 32'h200 : 32'h400);
    bus.mem_resp = 1; settle();
    chk("tie2_iresp", bus.i_resp, tie_first_d);
    step();
    bus.mem_resp = 0; bus.i_read = 0; bus.d_read = 0;

    // Abandoned D read
    step();
    bus.d_read = 1; bus.d_address = 32'h0000_0800;
    step(); settle();
    chk("abd_read", bus.mem_read, 1'b1);
    step();
    bus.d_read = 0;
    repeat (2) step();
    settle();
    chk("abd_held", bus.mem_read, 1'b1);
    bus.mem_resp = 1; settle();
    chk("abd_resp", bus.d_resp, 1'b1);
    step();
    bus.mem_resp = 0; settle();
    chk("abd_idle", bus.mem_read, 1'b0);

    // mem_resp while idle is ignored
    bus.mem_resp = 1; settle();
    chk("idle_iresp", bus.i_resp, 1'b0);
    chk("idle_dresp", bus.d_resp, 1'b0);
    step();
    bus.mem_resp = 0;

    // Reset in the middle of an I read
    bus.i_read = 1; bus.i_address = 32'h0000_0080;
    step(); settle();
    chk("rmid_read", bus.mem_read, 1'b1);
    step();
    rst = 1'b0; settle();
    chk("rmid_drop", bus.mem_read, 1'b0);
    bus.mem_resp = 1; settle();
    chk("rmid_noresp", bus.i_resp, 1'b0);
    step();
    bus.mem_resp = 0;
    step();
    rst = 1'b1;
    step(); settle();
    chk("rmid_regrant", bus.mem_read, 1'b1);
    chk("rmid_addr", bus.mem_address, 32'h80);
    bus.mem_resp = 1; settle();
    chk("rmid_resp", bus.i_resp, 1'b1);
    step();
    bus.mem_resp = 0; bus.i_read = 0;

    // Randomized traffic: caches hold requests until resp (occasionally
    // abandoning), memory answers randomly, including while idle.
    for (int c = 0; c < 4000; c++) begin
      ir_seen = bus.i_resp;
      dr_seen = bus.d_resp;
      step();
      if (bus.i_read) begin
        if (ir_seen || $urandom_range(99) < 2) bus.i_read = 0;
      end else if ($urandom_range(99) < 30) begin
        bus.i_read = 1;
        bus.i_address = {$urandom_range(32'hFFFF), 5'b0};
      end
      if (bus.d_read || bus.d_write) begin
        if (dr_seen || $urandom_range(99) < 2) begin
          bus.d_read = 0; bus.d_write = 0;
        end
      end else if ($urandom_range(99) < 30) begin
        bus.d_address = {$urandom_range(32'hFFFF), 5'b0};
        bus.d_wdata = rand_line();
        case ($urandom_range(19))
          0:       begin bus.d_read = 1; bus.d_write = 1; end
          1,2,3,4,5,6,7,8,9: begin bus.d_read = 0; bus.d_write = 1; end
          default: begin bus.d_read = 1; bus.d_write = 0; end
        endcase
      end
      line_rd = rand_line();
      bus.mem_rdata = line_rd;
      bus.mem_resp = ($urandom_range(99) < 30);
    end
    step();
    bus.i_read = 0; bus.d_read = 0; bus.d_write = 0; bus.mem_resp = 0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
